mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..15: consecutive lost cycles after which the instruction requester wins.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch read request; i_addr input `ISIZE.
REQ-005 i_ack  output  1  fetch accepted this cycle; i_rdata output `DSIZE; i_rvalid output 1.
REQ-006 d_req  input  1  data request; d_wen input 1 (1=write); d_addr input `ISIZE; d_wdata input `DSIZE.
REQ-007 d_ack  output  1  data request accepted this cycle; d_rdata output `DSIZE; d_rvalid output 1.
REQ-008 m_wen  output  1; m_addr output `ISIZE; m_wdata output `DSIZE; m_rdata input `DSIZE: single shared memory port (combinational read, posedge write).

Function
REQ-009 Requesters SHALL hold req/addr/wen/wdata stable until ack; ack is combinational in the cycle the request is served.
REQ-010 At most one of {fetch, data access, buffer drain} SHALL drive the memory port per cycle; m_wen=0 whenever no write is granted.
REQ-011 Default priority SHALL be data over fetch.
REQ-012 Starvation counter: increments when i_req=1 and i_ack=0; clears on i_ack or i_req=0; saturates at 15.
REQ-013 When counter >= STARVE_LIMIT, fetch SHALL win that cycle over data.
REQ-014 Read served in cycle t: m_rdata (or forwarded data) SHALL be registered into i_rdata/d_rdata, and i_rvalid/d_rvalid SHALL pulse high for exactly cycle t+1.
REQ-015 Read data outputs SHALL hold their value until the next read to the same requester completes.
REQ-016 Port-owner register SHALL take states IDLE, IFETCH, DREAD, DWRITE, DRAIN and is updated each posedge from the grant; it steers REQ-014.
REQ-017 Simultaneous fetch and data writes to the same address: the grant order defines the result; no merging.

Reset
REQ-018 rst low SHALL immediately force i_ack=d_ack=m_wen=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, owner=IDLE, starvation counter=0, write buffer invalid.
REQ-019 Reset mid-transaction SHALL discard any pending read response and buffered write; memory contents are not this block's responsibility.
REQ-020 Requests SHALL be honoured from the first posedge after rst rises.

Configuration
REQ-021 Macro MEM_WBUF_EN compiles in a single-entry posted write buffer (address, data, valid).
REQ-022 With MEM_WBUF_EN: a data write with buffer empty SHALL be acked without using the port and captured at posedge.
REQ-023 With MEM_WBUF_EN: buffer SHALL drain (DRAIN) in any cycle with no other port grant; if full and a new data write arrives, drain that cycle and withhold d_ack.
REQ-024 With MEM_WBUF_EN: a read (fetch or data) whose address matches a valid buffer entry SHALL return buffer data with the REQ-014 timing and use no port cycle.
REQ-025 Without MEM_WBUF_EN: data writes SHALL go directly to the port (DWRITE), acked the same cycle; DRAIN is unreachable.

Structure
REQ-026 Owner-state encoding and the STARVE_LIMIT default SHALL live in a shared package/define file alongside `ISIZE/`DSIZE.
REQ-027 The write buffer SHALL be a sub-module mem_wbuf, instantiated only under MEM_WBUF_EN.

Verification
REQ-028 Fetch only: i_req=1, i_addr=3, memory[3]=0x00430800 -> i_ack same cycle, i_rvalid next cycle with i_rdata=0x00430800.
REQ-029 Contention: i_req and d_req (read, addr 5) held continuously, STARVE_LIMIT=4 -> data acked 4 cycles, fetch acked on 5th, counter cleared.
REQ-030 Direct write (no MEM_WBUF_EN): d_wen=1, d_addr=10, d_wdata=0x18E40001 -> m_wen=1, m_addr=10 same cycle; later read of 10 returns 0x18E40001.
REQ-031 MEM_WBUF_EN: write 0xDEADBEEF to 12 while fetch active, then data read of 12 -> d_rdata=0xDEADBEEF via forwarding; buffer drains in first idle cycle.
REQ-032 MEM_WBUF_EN: two back-to-back writes with fetch hogging -> second d_ack withheld until drain cycle.
REQ-033 rst low during a granted read -> no rvalid pulse; all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, port-owner encoding and starvation defaults for mem_port_arbiter.
// The optional posted write buffer is compiled in with MEM_WBUF_EN.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

package mem_port_arbiter_pkg;

  localparam int unsigned AW                   = `ISIZE;
  localparam int unsigned DW                   = `DSIZE;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned STARVE_CNT_W         = 4;
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = 4'd15;

  typedef enum logic [2:0] {
    OWN_IDLE   = 3'd0,
    OWN_IFETCH = 3'd1,
    OWN_DREAD  = 3'd2,
    OWN_DWRITE = 3'd3,
    OWN_DRAIN  = 3'd4
  } owner_e;

  // Saturating count of consecutive cycles the fetch side asked and lost.
  function automatic logic [STARVE_CNT_W-1:0] starve_next(
    input logic [STARVE_CNT_W-1:0] cnt,
    input logic                    lost
  );
    logic [STARVE_CNT_W-1:0] res;
    res = '0;
    if (lost) begin
      res = (cnt == STARVE_MAX) ? STARVE_MAX : cnt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wbuf.sv
// Single-entry posted write buffer (address, data, valid) used by mem_port_arbiter.
// Only instantiated when MEM_WBUF_EN is defined.
module mem_wbuf
  import mem_port_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // A load only happens with the entry empty, so it never collides with a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory port,
// with fetch starvation protection. Define MEM_WBUF_EN for the posted write buffer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [`ISIZE-1:0] i_addr,
  output logic              i_ack,
  output logic [`DSIZE-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [`ISIZE-1:0] d_addr,
  input  logic [`DSIZE-1:0] d_wdata,
  output logic              d_ack,
  output logic [`DSIZE-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              m_wen,
  output logic [`ISIZE-1:0] m_addr,
  output logic [`DSIZE-1:0] m_wdata,
  input  logic [`DSIZE-1:0] m_rdata
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

`ifdef MEM_WBUF_EN
  localparam logic WBUF = 1'b1;
  logic wb_load;
  logic wb_drain;

  mem_wbuf u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (wb_load),
    .drain_i (wb_drain),
    .addr_i  (d_addr),
    .data_i  (d_wdata),
    .valid_o (wb_valid),
    .addr_o  (wb_addr),
    .data_o  (wb_data)
  );
`else
  localparam logic WBUF = 1'b0;
  assign wb_valid = 1'b0;
  assign wb_addr  = '0;
  assign wb_data  = '0;
`endif

  owner_e                  owner_q;
  owner_e                  grant;
  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;
  logic                    i_fwd_q;
  logic                    d_fwd_q;
  logic [DW-1:0]           i_rdata_q;
  logic [DW-1:0]           d_rdata_q;

  logic fwd_i;
  logic fwd_d;
  logic i_port;
  logic d_port;
  logic i_free;
  logic d_free;
  logic starve;

  assign fwd_i  = wb_valid && (wb_addr == i_addr);
  assign fwd_d  = wb_valid && (wb_addr == d_addr);
  assign starve = (cnt_q >= LIMIT);

  // Which requests need the shared port and which complete without it
  // (buffered write into an empty entry, or a read hitting the buffer).
  assign d_port = d_req && (d_wen ? (!WBUF || wb_valid) : !fwd_d);
  assign d_free = d_req && !d_port;
  assign i_port = i_req && !fwd_i;
  assign i_free = i_req && fwd_i;

  always_comb begin
    grant = OWN_IDLE;
    i_ack = 1'b0;
    d_ack = 1'b0;
    if (d_port && !(i_port && starve)) begin
      if (!d_wen) begin
        grant = OWN_DREAD;
        d_ack = 1'b1;
      end else if (WBUF) begin
        grant = OWN_DRAIN;
      end else begin
        grant = OWN_DWRITE;
        d_ack = 1'b1;
      end
    end else if (i_port) begin
      grant = OWN_IFETCH;
      i_ack = 1'b1;
    end else if (wb_valid) begin
      grant = OWN_DRAIN;
    end
    if (d_free) begin
      d_ack = 1'b1;
    end
    if (i_free) begin
      i_ack = 1'b1;
    end
    if (!rst) begin
      grant = OWN_IDLE;
      i_ack = 1'b0;
      d_ack = 1'b0;
    end
  end

  always_comb begin
    m_wen   = (grant == OWN_DWRITE) || (grant == OWN_DRAIN);
    m_wdata = (grant == OWN_DRAIN) ? wb_data : d_wdata;
    case (grant)
      OWN_DREAD, OWN_DWRITE: m_addr = d_addr;
      OWN_DRAIN:             m_addr = wb_addr;
      default:               m_addr = i_addr;
    endcase
  end

`ifdef MEM_WBUF_EN
  assign wb_load  = d_ack && d_wen;
  assign wb_drain = (grant == OWN_DRAIN);
`endif

  assign cnt_d = starve_next(cnt_q, i_req && !i_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_IDLE;
      cnt_q     <= '0;
      i_fwd_q   <= 1'b0;
      d_fwd_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q <= grant;
      cnt_q   <= cnt_d;
      i_fwd_q <= i_free;
      d_fwd_q <= d_free && !d_wen;
      if (i_ack) begin
        i_rdata_q <= fwd_i ? wb_data : m_rdata;
      end
      if (d_ack && !d_wen) begin
        d_rdata_q <= fwd_d ? wb_data : m_rdata;
      end
    end
  end

  // The registered owner marks the cycle after a port read; buffer hits use their own flags.
  assign i_rvalid = (owner_q == OWN_IFETCH) || i_fwd_q;
  assign d_rvalid = (owner_q == OWN_DREAD) || d_fwd_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected read data,
// a negedge monitor pops and compares on every rvalid pulse.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

module tb_mem_port_arbiter;

  localparam int AW = `ISIZE;
  localparam int DW = `DSIZE;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_rvalid;
  logic          d_req = 1'b0;
  logic          d_wen = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_rvalid;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  logic [DW-1:0] last_i = '0;
  logic [DW-1:0] last_d = '0;

  // Memory model: combinational read, posedge write, plus a preload path.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign m_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (m_wen) mem[m_addr] <= m_wdata;
  end

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .i_rvalid (i_rvalid),
    .d_req    (d_req),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_rvalid (d_rvalid),
    .m_wen    (m_wen),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic push_i(input logic [DW-1:0] v);
    i_exp_q.push_back(v);
    last_i = v;
  endtask

  task automatic push_d(input logic [DW-1:0] v);
    d_exp_q.push_back(v);
    last_d = v;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Monitor: one line per read response, compared against the scoreboard.
  always @(negedge clk) begin
    if (rst && i_rvalid) begin
      if (i_exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL i_rvalid_unexpected: got response 0x%08h, required none", i_rdata);
      end else begin
        check("i_rdata", i_rdata, i_exp_q.pop_front());
        $display("fetch response i_rdata=0x%08h", i_rdata);
      end
    end
    if (rst && d_rvalid) begin
      if (d_exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL d_rvalid_unexpected: got response 0x%08h, required none", d_rdata);
      end else begin
        check("d_rdata", d_rdata, d_exp_q.pop_front());
        $display("data response d_rdata=0x%08h", d_rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] exp_d_tab;
  logic [5:0] exp_i_tab;

  initial begin
    // Requests raised during reset must not be acked or reach the port.
    i_req = 1'b1; d_req = 1'b1; d_wen = 1'b1; d_wdata = 32'h0BAD0BAD;
    preload(16'd3, 32'h00430800);
    preload(16'd5, 32'h55550005);
    preload(16'd7, 32'h77770007);
    @(negedge clk);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_m_wen", m_wen, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Fetch only
    i_req = 1'b1; i_addr = 16'd3;
    @(negedge clk);
    check("fetch_i_ack", i_ack, 1);
    check("fetch_m_addr", m_addr, 3);
    check("fetch_m_wen", m_wen, 0);
    push_i(32'h00430800);
    $display("fetch issued addr=3");
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_rvalid_t1", i_rvalid, 1);
    @(negedge clk);
    check("fetch_rvalid_t2", i_rvalid, 0);
    check("idle_m_wen", m_wen, 0);

    // Contention: data wins 4 cycles, fetch wins the 5th, then data again
    exp_d_tab = 6'b101111;
    exp_i_tab = 6'b010000;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'd7; d_req = 1'b1; d_wen = 1'b0; d_addr = 16'd5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("cont_d_ack_c%0d", c), d_ack, exp_d_tab[c]);
      check($sformatf("cont_i_ack_c%0d", c), i_ack, exp_i_tab[c]);
      if (exp_d_tab[c]) push_d(32'h55550005);
      if (exp_i_tab[c]) push_i(32'h77770007);
      $display("contention cycle %0d d_ack=%0d i_ack=%0d", c, d_ack, i_ack);
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;

`ifdef MEM_WBUF_EN
    // Posted write while fetch runs, then forwarded read, then drain when idle
    i_req = 1'b1; i_addr = 16'd3; d_req = 1'b1; d_wen = 1'b1; d_addr = 16'd12; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("wb_w_d_ack", d_ack, 1);
    check("wb_w_i_ack", i_ack, 1);
    check("wb_w_m_wen", m_wen, 0);
    check("wb_w_m_addr", m_addr, 3);
    push_i(32'h00430800);
    @(posedge clk); #1;
    d_wen = 1'b0;
    @(negedge clk);
    check("wb_fwd_d_ack", d_ack, 1);
    check("wb_fwd_i_ack", i_ack, 1);
    check("wb_fwd_m_wen", m_wen, 0);
    push_d(32'hDEADBEEF);
    push_i(32'h00430800);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("wb_drain_m_wen", m_wen, 1);
    check("wb_drain_m_addr", m_addr, 12);
    check("wb_drain_m_wdata", m_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("wb_after_drain_m_wen", m_wen, 0);

    // Back-to-back writes with fetch active: second ack waits for the drain
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'd3; d_req = 1'b1; d_wen = 1'b1; d_addr = 16'd20; d_wdata = 32'hA0A0A0A0;
    @(negedge clk);
    check("b2b_first_d_ack", d_ack, 1);
    check("b2b_first_i_ack", i_ack, 1);
    push_i(32'h00430800);
    @(posedge clk); #1;
    d_addr = 16'd21; d_wdata = 32'hB1B1B1B1;
    @(negedge clk);
    check("b2b_second_d_ack_withheld", d_ack, 0);
    check("b2b_drain_m_wen", m_wen, 1);
    check("b2b_drain_m_addr", m_addr, 20);
    check("b2b_drain_i_ack", i_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_second_d_ack", d_ack, 1);
    check("b2b_second_i_ack", i_ack, 1);
    push_i(32'h00430800);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    @(negedge clk);
    check("b2b_drain2_m_wen", m_wen, 1);
    check("b2b_drain2_m_addr", m_addr, 21);
    check("b2b_drain2_m_wdata", m_wdata, 32'hB1B1B1B1);
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 16'd21;
    @(negedge clk);
    check("b2b_readback_d_ack", d_ack, 1);
    check("b2b_readback_m_addr", m_addr, 21);
    push_d(32'hB1B1B1B1);
    @(posedge clk); #1;
    d_req = 1'b0;
`else
    // Direct write goes straight to the port, then read it back
    d_req = 1'b1; d_wen = 1'b1; d_addr = 16'd10; d_wdata = 32'h18E40001;
    @(negedge clk);
    check("dw_d_ack", d_ack, 1);
    check("dw_m_wen", m_wen, 1);
    check("dw_m_addr", m_addr, 10);
    check("dw_m_wdata", m_wdata, 32'h18E40001);
    $display("data write addr=10 data=0x18e40001");
    @(posedge clk); #1;
    d_wen = 1'b0;
    @(negedge clk);
    check("dr_d_ack", d_ack, 1);
    check("dr_m_wen", m_wen, 0);
    push_d(32'h18E40001);
    @(posedge clk); #1;
    d_req = 1'b0;
`endif

    // Read data holds across idle cycles
    repeat (3) @(negedge clk);
    check("hold_i_rdata", i_rdata, last_i);
    check("hold_d_rdata", d_rdata, last_d);

    // Reset in the middle of a granted read
    @(posedge clk); #1;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 16'd3;
    @(negedge clk);
    check("rstmid_d_ack_before", d_ack, 1);
    #1 rst = 1'b0;
    #1;
    check("rstmid_i_ack", i_ack, 0);
    check("rstmid_d_ack", d_ack, 0);
    check("rstmid_m_wen", m_wen, 0);
    check("rstmid_i_rvalid", i_rvalid, 0);
    check("rstmid_d_rvalid", d_rvalid, 0);
    check("rstmid_i_rdata", i_rdata, 0);
    check("rstmid_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 16'd3;
    @(negedge clk);
    check("postrst_i_ack", i_ack, 1);
    check("postrst_d_rvalid", d_rvalid, 0);
    push_i(32'h00430800);
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    check("i_queue_drained", i_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
